// File: rtl/asteroids_dl_pkg.sv
`default_nettype none
// ============================================================================
// Module     : asteroids_dl_pkg
// Description: Shared state encoding and default ROM region map for the
//              Asteroids ROM download sequencer.
// Revision   : 1.0
// ============================================================================
package asteroids_dl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } dl_state_t;

    localparam logic [15:0] DEF_PROG_BASE  = 16'h0000;
    localparam logic [15:0] DEF_PROG_SIZE  = 16'h2000;
    localparam logic [15:0] DEF_VEC_BASE   = 16'h2000;
    localparam logic [15:0] DEF_VEC_SIZE   = 16'h0800;
    localparam int          DEF_SETTLE_CYC = 64;

endpackage
`default_nettype wire

// File: rtl/rom_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module     : rom_load_sequencer_if
// Description: Download-side ioctl inputs, CPU read address and ROM RAM /
//              status outputs of the ROM load sequencer.
// Revision   : 1.0
// ============================================================================
interface rom_load_sequencer_if;

    logic        dn_download;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [15:0] cpu_addr;
    logic [15:0] rom_addr;
    logic [7:0]  rom_din;
    logic        prog_we;
    logic        vec_we;
    logic        cpu_reset_l;
    logic        dl_done;
    logic [7:0]  dl_sum;
    logic        dl_err;

    modport master (
        output dn_download, dn_wr, dn_addr, dn_data, cpu_addr,
        input  rom_addr, rom_din, prog_we, vec_we, cpu_reset_l,
               dl_done, dl_sum, dl_err
    );

    modport slave (
        input  dn_download, dn_wr, dn_addr, dn_data, cpu_addr,
        output rom_addr, rom_din, prog_we, vec_we, cpu_reset_l,
               dl_done, dl_sum, dl_err
    );

endinterface
`default_nettype wire

// File: rtl/dl_region_decode.sv
`default_nettype none
// ============================================================================
// Module     : dl_region_decode
// Description: Combinational byte-address decode into program ROM, vector
//              ROM or out-of-range.
// Revision   : 1.0
// ============================================================================
module dl_region_decode
    import asteroids_dl_pkg::*;
#(
    parameter logic [15:0] PROG_BASE = DEF_PROG_BASE,
    parameter logic [15:0] PROG_SIZE = DEF_PROG_SIZE,
    parameter logic [15:0] VEC_BASE  = DEF_VEC_BASE,
    parameter logic [15:0] VEC_SIZE  = DEF_VEC_SIZE
) (
    input  logic [15:0] addr,
    output logic        prog_hit,
    output logic        vec_hit,
    output logic        miss
);

    // 17-bit offsets: an address below the base wraps far above any size,
    // and base+size reaching 64K does not overflow.
    logic [16:0] w_prog_off;
    logic [16:0] w_vec_off;
    logic        w_in_prog;
    logic        w_in_vec;

    assign w_prog_off = {1'b0, addr} - {1'b0, PROG_BASE};
    assign w_vec_off  = {1'b0, addr} - {1'b0, VEC_BASE};
    assign w_in_prog  = (w_prog_off < {1'b0, PROG_SIZE});
    assign w_in_vec   = (w_vec_off  < {1'b0, VEC_SIZE});

    assign prog_hit = w_in_prog;
    assign vec_hit  = w_in_vec & ~w_in_prog;
    assign miss     = ~w_in_prog & ~w_in_vec;

endmodule
`default_nettype wire

// File: rtl/rom_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : rom_load_sequencer
// Description: Sequences HPS ROM download into the program / vector ROM RAMs,
//              holds the CPU in reset until a settle window elapses.
// Revision   : 1.0
// ============================================================================
module rom_load_sequencer
    import asteroids_dl_pkg::*;
#(
    parameter logic [15:0] PROG_BASE  = DEF_PROG_BASE,
    parameter logic [15:0] PROG_SIZE  = DEF_PROG_SIZE,
    parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [15:0] VEC_SIZE   = DEF_VEC_SIZE,
    parameter int          SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  wire logic            clk_25,
    input  wire logic            RESET_L,
    rom_load_sequencer_if.slave  bus
);

    localparam int              CW         = $clog2(SETTLE_CYC);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(SETTLE_CYC - 1);

    dl_state_t     r_state;
    dl_state_t     w_state_nxt;
    logic          w_load_entry;
    logic          w_settle_done;
    logic          w_accept;
    logic          w_prog_hit;
    logic          w_vec_hit;
    logic          w_miss;

    logic          r_pend;
    logic [15:0]   r_addr;
    logic [7:0]    r_din;
    logic          r_prog_we;
    logic          r_vec_we;
    logic          r_cpu_reset_l;
    logic          r_done;
    logic [7:0]    r_sum;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    assign w_accept = bus.dn_download & bus.dn_wr;

    dl_region_decode #(
        .PROG_BASE (PROG_BASE),
        .PROG_SIZE (PROG_SIZE),
        .VEC_BASE  (VEC_BASE),
        .VEC_SIZE  (VEC_SIZE)
    ) u_decode (
        .addr     (bus.dn_addr),
        .prog_hit (w_prog_hit),
        .vec_hit  (w_vec_hit),
        .miss     (w_miss)
    );

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) r_state <= ST_BOOT;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_settle_done = 1'b0;
        case (r_state)
            ST_BOOT:   if (bus.dn_download) w_state_nxt = ST_LOAD;
            ST_LOAD:   if (!bus.dn_download) w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (bus.dn_download) begin
                    w_state_nxt = ST_LOAD;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt   = ST_RUN;
                    w_settle_done = 1'b1;
                end
            end
            ST_RUN:    if (bus.dn_download) w_state_nxt = ST_LOAD;
            default:   w_state_nxt = ST_BOOT;
        endcase
        w_load_entry = (r_state != ST_LOAD) && (w_state_nxt == ST_LOAD);
    end

    // Decoding the incoming address and registering the enables is the same
    // as decoding the captured address one cycle later, with no comb output.
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            r_pend        <= 1'b0;
            r_addr        <= '0;
            r_din         <= '0;
            r_prog_we     <= 1'b0;
            r_vec_we      <= 1'b0;
            r_cpu_reset_l <= 1'b0;
            r_done        <= 1'b0;
            r_sum         <= '0;
            r_err         <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_pend        <= w_accept;
            r_prog_we     <= w_accept & w_prog_hit;
            r_vec_we      <= w_accept & w_vec_hit;
            r_cpu_reset_l <= (w_state_nxt == ST_RUN);
            if (w_accept) begin
                r_addr <= bus.dn_addr;
                r_din  <= bus.dn_data;
            end
            if ((r_state == ST_SETTLE) && (w_state_nxt == ST_SETTLE)) r_cnt <= r_cnt + CW'(1);
            else                                                      r_cnt <= '0;
            // A byte arriving on the re-entry edge is the first of the new download.
            if (w_load_entry) begin
                r_done <= 1'b0;
                r_sum  <= (w_accept && !w_miss) ? bus.dn_data : 8'h00;
                r_err  <= w_accept & w_miss;
            end else begin
                if (w_settle_done) r_done <= 1'b1;
                if (w_accept) begin
                    if (w_miss) r_err <= 1'b1;
                    else        r_sum <= r_sum + bus.dn_data;
                end
            end
        end
    end

    assign bus.rom_addr    = ((r_state == ST_LOAD) || r_pend) ? r_addr : bus.cpu_addr;
    assign bus.rom_din     = r_din;
    assign bus.prog_we     = r_prog_we;
    assign bus.vec_we      = r_vec_we;
    assign bus.cpu_reset_l = r_cpu_reset_l;
    assign bus.dl_done     = r_done;
    assign bus.dl_sum      = r_sum;
    assign bus.dl_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rom_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : tb_rom_load_sequencer
// Description: Directed + random stimulus bench with a region-map reference
//              model and a scoreboard of expected ROM writes.
// Revision   : 1.0
// ============================================================================
module tb_rom_load_sequencer;

    localparam int PB = 'h0000, PS = 'h2000, VB = 'h2000, VS = 'h0800;
    localparam int SETTLE = 64;

    typedef struct {
        bit          vec;
        logic [15:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    logic clk_25 = 1'b0;
    logic RESET_L;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_prog = 0;
    int   n_vec = 0;
    logic [7:0] m_sum = 8'h00;
    logic       m_err = 1'b0;
    wr_t  expq[$];

    rom_load_sequencer_if bus ();

    rom_load_sequencer #(
        .PROG_BASE  (16'h0000),
        .PROG_SIZE  (16'h2000),
        .VEC_BASE   (16'h2000),
        .VEC_SIZE   (16'h0800),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk_25  (clk_25),
        .RESET_L (RESET_L),
        .bus     (bus)
    );

    always #5 clk_25 = ~clk_25;
    always @(posedge clk_25) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 1 = program ROM, 2 = vector ROM, 0 = outside both
    function automatic int region(input int a);
        if (a >= PB && a < PB + PS) return 1;
        if (a >= VB && a < VB + VS) return 2;
        return 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_25);
        #1;
    endtask

    task automatic dl_start();
        bus.dn_download = 1'b1;
        m_sum = 8'h00;
        m_err = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        int r;
        r = region(int'(a));
        bus.dn_wr   = 1'b1;
        bus.dn_addr = a;
        bus.dn_data = d;
        if (r != 0) begin
            expq.push_back('{(r == 2), a, d, cyc + 1});
            m_sum = m_sum + d;
        end else begin
            m_err = 1'b1;
        end
        tick(1);
    endtask

    task automatic dl_end();
        bus.dn_wr       = 1'b0;
        bus.dn_download = 1'b0;
    endtask

    // Every observed write must match the next expected one, one cycle after its strobe.
    always @(negedge clk_25) begin
        wr_t e;
        if (bus.prog_we === 1'b1 || bus.vec_we === 1'b1) begin
            if (bus.vec_we === 1'b1) n_vec++;
            else                     n_prog++;
            if (expq.size() == 0) begin
                chk("unexpected_we", {bus.vec_we, bus.prog_we}, 0);
            end else begin
                e = expq.pop_front();
                chk("we_kind", {30'd0, bus.vec_we, bus.prog_we}, e.vec ? 2'b10 : 2'b01);
                chk("we_addr_data", {8'd0, bus.rom_addr, bus.rom_din}, {8'd0, e.a, e.d});
                chk("we_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ca;
        RESET_L         = 1'b1;
        bus.dn_download = 1'b0;
        bus.dn_wr       = 1'b0;
        bus.dn_addr     = 16'h0;
        bus.dn_data     = 8'h0;
        bus.cpu_addr    = 16'h1234;
        #2 RESET_L = 1'b0;
        #1;
        chk("rst_cpu_reset_l", bus.cpu_reset_l, 0);
        chk("rst_we", {bus.prog_we, bus.vec_we}, 0);
        chk("rst_rom_din", bus.rom_din, 0);
        chk("rst_status", {bus.dl_done, bus.dl_sum, bus.dl_err}, 0);
        tick(3);
        RESET_L = 1'b1;

        // Idle with stray strobes outside a download window
        for (int i = 0; i < 100; i++) begin
            bus.dn_wr    = 1'($urandom);
            bus.dn_addr  = 16'($urandom);
            bus.dn_data  = 8'($urandom);
            bus.cpu_addr = 16'($urandom);
            tick(1);
        end
        bus.dn_wr = 1'b0;
        chk("idle_cpu_reset_l", bus.cpu_reset_l, 0);
        chk("idle_done", bus.dl_done, 0);
        chk("idle_rom_addr", bus.rom_addr, bus.cpu_addr);

        // Basic download; first byte arrives on the rising edge of dn_download
        dl_start();
        for (int i = 0; i < 16; i++) wr(16'(i), 8'(i + 1));
        bus.dn_wr = 1'b0;
        tick(2);
        wr(16'h2000, 8'hAA);
        bus.dn_wr = 1'b0;
        chk("dl_sum_basic", bus.dl_sum, 8'h32);
        chk("dl_err_basic", bus.dl_err, 0);

        wr(16'h3000, 8'h55);
        bus.dn_wr = 1'b0;
        chk("miss_err", bus.dl_err, 1);
        chk("miss_sum", bus.dl_sum, 8'h32);

        dl_end();
        tick(SETTLE);
        chk("settle_edge_minus1_rst", bus.cpu_reset_l, 0);
        chk("settle_edge_minus1_done", bus.dl_done, 0);
        tick(1);
        chk("settle_edge_rst", bus.cpu_reset_l, 1);
        chk("settle_edge_done", bus.dl_done, 1);
        chk("run_sum_err", {bus.dl_sum, bus.dl_err}, {m_sum, m_err});
        for (int i = 0; i < 4; i++) begin
            ca = 16'($urandom);
            bus.cpu_addr = ca;
            #1;
            chk("run_rom_addr", bus.rom_addr, ca);
        end
        tick(1);

        // Re-download from RUN, then re-rise mid-settle
        dl_start();
        tick(1);
        chk("rerun_cpu_reset_l", bus.cpu_reset_l, 0);
        chk("rerun_clear", {bus.dl_done, bus.dl_sum, bus.dl_err}, 0);
        for (int i = 0; i < 5; i++) wr(16'($urandom_range(0, 'h27FF)), 8'($urandom));
        dl_end();
        tick(31);
        chk("settle30_rst", bus.cpu_reset_l, 0);
        dl_start();
        wr(16'h0100, 8'($urandom));
        bus.dn_wr = 1'b0;
        chk("rerise_sum", bus.dl_sum, m_sum);
        chk("rerise_rst", bus.cpu_reset_l, 0);
        dl_end();
        tick(SETTLE);
        chk("rerise_settle_minus1", bus.cpu_reset_l, 0);
        tick(1);
        chk("rerise_settle_full", {bus.cpu_reset_l, bus.dl_done}, 2'b11);

        // Sustained back-to-back full image
        n_prog = 0;
        n_vec  = 0;
        dl_start();
        for (int i = 0; i < 'h2800; i++) wr(16'(i), 8'($urandom));
        dl_end();
        tick(2);
        chk("burst_prog_cnt", n_prog, 'h2000);
        chk("burst_vec_cnt", n_vec, 'h800);
        chk("burst_sum_err", {bus.dl_sum, bus.dl_err}, {m_sum, m_err});
        tick(SETTLE);

        // Random addresses with gaps, mix of hits and misses
        dl_start();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) wr(16'($urandom_range(0, 'h2FFF)), 8'($urandom));
            else begin bus.dn_wr = 1'b0; tick(1); end
        end
        dl_end();
        tick(2);
        chk("rand_sum_err", {bus.dl_sum, bus.dl_err}, {m_sum, m_err});

        // Reset while a captured write is pending: no pulse reaches the RAM
        dl_start();
        tick(1);
        bus.dn_wr   = 1'b1;
        bus.dn_addr = 16'h0010;
        bus.dn_data = 8'h77;
        tick(1);
        RESET_L = 1'b0;
        #1;
        chk("rst_mid_we", {bus.prog_we, bus.vec_we}, 0);
        chk("rst_mid_outs", {bus.cpu_reset_l, bus.dl_done, bus.dl_sum, bus.dl_err, bus.rom_din}, 0);
        dl_end();
        tick(2);
        RESET_L = 1'b1;
        tick(5);
        ca = 16'($urandom);
        bus.cpu_addr = ca;
        #1;
        chk("post_rst_rom_addr", bus.rom_addr, ca);
        chk("post_rst_cpu_reset_l", bus.cpu_reset_l, 0);
        chk("scoreboard_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
